bist_data_gen: RTL and testbench

//  Address/data source for one march element of the PMBIST engine. Steps the

---
 rtl/bist_data_gen_pkg.sv | 38 +++
 rtl/bist_exp_pipe.sv | 37 +++
 rtl/bist_data_gen.sv | 108 ++++++++++
 tb/tb_bist_data_gen.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_data_gen_pkg.sv
// Shared widths, background/state encodings and the background pattern
// function used by the PMBIST address/data generator.
package bist_data_gen_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        BG_SOLID = 2'b00,
        BG_CHK   = 2'b01,
        BG_ROW   = 2'b10,
        BG_COL   = 2'b11
    } bg_sel_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Only the address LSB matters for every background we support.
    function automatic logic [DATA_WIDTH-1:0] pat(input bg_sel_t bg_sel,
                                                  input logic    addr_lsb,
                                                  input logic    inv);
        logic [DATA_WIDTH-1:0] chk;
        logic [DATA_WIDTH-1:0] bg;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            chk[i] = ((i % 2) == 0);
        end
        case (bg_sel)
            BG_SOLID: bg = '0;
            BG_CHK:   bg = chk ^ {DATA_WIDTH{addr_lsb}};
            BG_ROW:   bg = {DATA_WIDTH{addr_lsb}};
            default:  bg = chk;
        endcase
        return bg ^ {DATA_WIDTH{inv}};
    endfunction

endpackage

// File: rtl/bist_exp_pipe.sv
// Delay line that carries expected read data so it arrives at the
// comparator in the same cycle as the memory's read data.
module bist_exp_pipe #(
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic [RD_LAT-1:0] valid_sr;
    logic [DW-1:0]     data_sr [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_sr <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                data_sr[i] <= '0;
            end
        end else begin
            valid_sr[0] <= in_valid;
            data_sr[0]  <= in_data;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                data_sr[i]  <= data_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[RD_LAT-1];
    assign out_data  = data_sr[RD_LAT-1];

endmodule

// File: rtl/bist_data_gen.sv
// Address/data source for one march element: walks the address range,
// drives the memory port and produces latency-aligned expected read data.
module bist_data_gen
    import bist_data_gen_pkg::*;
#(
    parameter int DW     = DATA_WIDTH,
    parameter int AW     = ADDR_WIDTH,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          dir,
    input  logic [1:0]    bg_sel,
    input  logic          op_valid,
    input  logic          op_wr,
    input  logic          op_inv,
    input  logic          last_op,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_re,
    output logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] exp_data,
    output logic          exp_valid,
    output logic          busy,
    output logic          elem_done
);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] addr;
    logic          dir_q;
    logic          accept;
    logic          at_final;
    logic          finish;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN: begin
                if (start) begin
                    state_next = ST_RUN;
                end else if (finish) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // start has priority over an op presented in the same cycle.
    always_comb begin
        accept   = (state == ST_RUN) && op_valid && !start;
        at_final = dir_q ? (addr == '0) : (addr == '1);
        finish   = accept && last_op && at_final;
    end

    assign busy = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            dir_q     <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_wdata <= '0;
            elem_done <= 1'b0;
        end else begin
            mem_we    <= accept && op_wr;
            mem_re    <= accept && !op_wr;
            elem_done <= finish;
            if (start) begin
                dir_q <= dir;
                addr  <= dir ? '1 : '0;
            end else if (accept && last_op && !at_final) begin
                addr <= dir_q ? addr - 1'b1 : addr + 1'b1;
            end
            if (accept) begin
                mem_addr  <= addr;
                mem_wdata <= pat(bg_sel_t'(bg_sel), addr[0], op_inv);
            end
        end
    end

    // Read data is captured alongside mem_re, so the pipe only adds RD_LAT.
    bist_exp_pipe #(
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) u_exp_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (mem_re),
        .in_data   (mem_wdata),
        .out_valid (exp_valid),
        .out_data  (exp_data)
    );

endmodule

// File: tb/tb_bist_data_gen.sv
// Self-checking bench for bist_data_gen (AW=4, DW=8, RD_LAT=2): directed
// march scenarios plus random traffic against an event-level reference model.
module tb_bist_data_gen;

    localparam int AW     = 4;
    localparam int DW     = 8;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          dir;
    logic [1:0]    bg_sel;
    logic          op_valid;
    logic          op_wr;
    logic          op_inv;
    logic          last_op;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] exp_data;
    logic          exp_valid;
    logic          busy;
    logic          elem_done;

    int errors = 0;
    int checks = 0;

    bist_data_gen #(
        .DW     (DW),
        .AW     (AW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dir       (dir),
        .bg_sel    (bg_sel),
        .op_valid  (op_valid),
        .op_wr     (op_wr),
        .op_inv    (op_inv),
        .last_op   (last_op),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .exp_data  (exp_data),
        .exp_valid (exp_valid),
        .busy      (busy),
        .elem_done (elem_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change 1 time unit after the edge so both DUT and model see them stable.
    task automatic applyStimulus(input logic r, input logic s, input logic d,
                                 input logic [1:0] bg, input logic v, input logic wr,
                                 input logic inv, input logic lo);
        rst      = r;
        start    = s;
        dir      = d;
        bg_sel   = bg;
        op_valid = v;
        op_wr    = wr;
        op_inv   = inv;
        last_op  = lo;
        @(posedge clk);
        #1;
    endtask

    // Reference model: tracks the element as an integer address walk and a
    // list of scheduled read-data arrivals keyed by cycle number.
    typedef struct {
        int          due;
        logic [7:0]  data;
    } exp_ev_t;

    exp_ev_t    ev_q[$];
    int         cyc = 0;
    bit         model_ready = 0;
    bit         m_run;
    bit         m_dir;
    int         m_addr;
    logic [3:0] m_mem_addr;
    logic       m_mem_we;
    logic       m_mem_re;
    logic [7:0] m_mem_wdata;
    logic       m_exp_valid;
    logic [7:0] m_exp_data;
    logic       m_busy;
    logic       m_elem_done;

    function automatic logic [7:0] model_pat(input int bg, input int a, input bit inv);
        logic [7:0] b;
        case (bg)
            0:       b = 8'h00;
            1:       b = (a % 2 == 1) ? 8'hAA : 8'h55;
            2:       b = (a % 2 == 1) ? 8'hFF : 8'h00;
            default: b = 8'h55;
        endcase
        return inv ? ~b : b;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_run = 0; m_dir = 0; m_addr = 0;
            m_mem_addr = 0; m_mem_we = 0; m_mem_re = 0; m_mem_wdata = 0;
            m_exp_valid = 0; m_exp_data = 0; m_busy = 0; m_elem_done = 0;
            ev_q.delete();
        end else begin
            m_mem_we = 0;
            m_mem_re = 0;
            m_elem_done = 0;
            if (start) begin
                m_run  = 1;
                m_dir  = dir;
                m_addr = dir ? 15 : 0;
            end else if (m_run && op_valid) begin
                m_mem_addr  = 4'(m_addr);
                m_mem_wdata = model_pat(int'(bg_sel), m_addr, op_inv);
                m_mem_we    = op_wr;
                m_mem_re    = !op_wr;
                if (!op_wr) ev_q.push_back('{due: cyc + RD_LAT, data: m_mem_wdata});
                if (last_op) begin
                    if (m_addr == (m_dir ? 0 : 15)) begin
                        m_run = 0;
                        m_elem_done = 1;
                    end else begin
                        m_addr = m_dir ? m_addr - 1 : m_addr + 1;
                    end
                end
            end
            m_busy = m_run;
            m_exp_valid = 0;
            if (ev_q.size() > 0 && ev_q[0].due == cyc) begin
                m_exp_valid = 1;
                m_exp_data  = ev_q[0].data;
                void'(ev_q.pop_front());
            end
        end
        model_ready = 1;
    end

    always @(negedge clk) begin
        if (model_ready) begin
            checkOutput("mem_addr", 32'(mem_addr), 32'(m_mem_addr));
            checkOutput("mem_we", 32'(mem_we), 32'(m_mem_we));
            checkOutput("mem_re", 32'(mem_re), 32'(m_mem_re));
            checkOutput("mem_wdata", 32'(mem_wdata), 32'(m_mem_wdata));
            checkOutput("exp_valid", 32'(exp_valid), 32'(m_exp_valid));
            checkOutput("busy", 32'(busy), 32'(m_busy));
            checkOutput("elem_done", 32'(elem_done), 32'(m_elem_done));
            if (m_exp_valid) checkOutput("exp_data", 32'(exp_data), 32'(m_exp_data));
        end
    end

    initial begin
        rst = 1; start = 0; dir = 0; bg_sel = 0;
        op_valid = 0; op_wr = 0; op_inv = 0; last_op = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;

        // Reset state, and ops ignored while idle.
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_wdata", 32'(mem_wdata), 32'h0);
        checkOutput("rst_exp_data", 32'(exp_data), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_exp_valid", 32'(exp_valid), 32'h0);
        applyStimulus(0, 0, 0, 2'b00, 1, 1, 0, 1);
        checkOutput("idle_we", 32'(mem_we), 32'h0);
        applyStimulus(0, 0, 0, 2'b00, 1, 0, 0, 1);
        checkOutput("idle_re", 32'(mem_re), 32'h0);

        // Solid-background write sweep upward.
        applyStimulus(0, 1, 0, 2'b00, 0, 0, 0, 0);
        checkOutput("start_busy", 32'(busy), 32'h1);
        for (int a = 0; a < 16; a++) begin
            applyStimulus(0, 0, 0, 2'b00, 1, 1, 0, 1);
            checkOutput("up_addr", 32'(mem_addr), 32'(a));
            checkOutput("up_wdata", 32'(mem_wdata), 32'h00);
        end
        checkOutput("up_done", 32'(elem_done), 32'h1);
        checkOutput("up_busy_fall", 32'(busy), 32'h0);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0);
        checkOutput("done_pulse", 32'(elem_done), 32'h0);

        // Checkerboard reads downward, back to back.
        applyStimulus(0, 1, 1, 2'b01, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 2'b01, 1, 0, 0, 1);
        checkOutput("dn_first_addr", 32'(mem_addr), 32'hF);
        checkOutput("dn_first_re", 32'(mem_re), 32'h1);
        applyStimulus(0, 0, 0, 2'b01, 1, 0, 0, 1);
        checkOutput("dn_second_addr", 32'(mem_addr), 32'hE);
        checkOutput("exp_not_yet", 32'(exp_valid), 32'h0);
        applyStimulus(0, 0, 0, 2'b01, 0, 0, 0, 0);
        checkOutput("exp_lat_valid", 32'(exp_valid), 32'h1);
        checkOutput("exp_chk_15", 32'(exp_data), 32'hAA);
        applyStimulus(0, 0, 0, 2'b01, 0, 0, 0, 0);
        checkOutput("exp_b2b_valid", 32'(exp_valid), 32'h1);
        checkOutput("exp_chk_14", 32'(exp_data), 32'h55);
        for (int a = 13; a >= 0; a--) applyStimulus(0, 0, 0, 2'b01, 1, 0, 0, 1);
        checkOutput("dn_done", 32'(elem_done), 32'h1);

        // Inverted row stripe, then column stripe.
        applyStimulus(0, 1, 0, 2'b10, 0, 0, 0, 0);
        for (int a = 0; a < 4; a++) begin
            applyStimulus(0, 0, 0, 2'b10, 1, 1, 1, 1);
            if (a == 2) checkOutput("row_inv_a2", 32'(mem_wdata), 32'hFF);
            if (a == 3) checkOutput("row_inv_a3", 32'(mem_wdata), 32'h00);
        end
        for (int a = 4; a < 16; a++) begin
            applyStimulus(0, 0, 0, 2'b11, 1, 1, 0, 1);
            checkOutput("col_wdata", 32'(mem_wdata), 32'h55);
        end

        // r0,w1 element: two ops per address, advance only after the write.
        applyStimulus(0, 1, 0, 2'b00, 1, 1, 0, 1);
        checkOutput("start_drops_op", 32'(mem_we), 32'h0);
        for (int a = 0; a < 16; a++) begin
            applyStimulus(0, 0, 0, 2'b00, 1, 0, 0, 0);
            checkOutput("rw_read_addr", 32'(mem_addr), 32'(a));
            applyStimulus(0, 0, 0, 2'b00, 1, 1, 1, 1);
            checkOutput("rw_write_addr", 32'(mem_addr), 32'(a));
        end
        repeat (3) applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0);

        // Reset with reads in flight.
        applyStimulus(0, 1, 0, 2'b01, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 2'b01, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 2'b01, 1, 0, 0, 1);
        applyStimulus(1, 0, 0, 2'b01, 1, 0, 0, 1);
        checkOutput("rst_mid_exp", 32'(exp_valid), 32'h0);
        checkOutput("rst_mid_busy", 32'(busy), 32'h0);
        checkOutput("rst_mid_re", 32'(mem_re), 32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 2'b01, 0, 0, 0, 0);
            checkOutput("no_stale_exp", 32'(exp_valid), 32'h0);
        end

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 29) == 0),
                          1'($urandom), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                          1'($urandom_range(0, 2) != 0));
        end
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0);
        repeat (4) applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
